// File: rtl/robo_ambiente_if.sv
// Map RAM port between the robot environment model (master) and the map RAM (slave).
// Reads are synchronous: rd_data is valid one cycle after rd_row/rd_col.
interface robo_ambiente_if #(
  parameter int ROW_W  = 4,
  parameter int COL_W  = 5,
  parameter int CELL_W = 4
);
  logic [ROW_W-1:0]  rd_row;
  logic [COL_W-1:0]  rd_col;
  logic [CELL_W-1:0] rd_data;
  logic              wr_en;
  logic [ROW_W-1:0]  wr_row;
  logic [COL_W-1:0]  wr_col;
  logic [CELL_W-1:0] wr_data;

  modport master (
    output rd_row, rd_col, wr_en, wr_row, wr_col, wr_data,
    input  rd_data
  );

  modport slave (
    input  rd_row, rd_col, wr_en, wr_row, wr_col, wr_data,
    output rd_data
  );
endinterface

// File: rtl/robo_ambiente.sv
// Environment model for the pipe-inspection robot: tracks pose, reads the map,
// produces sensors and applies the controller's move/turn/debris-removal decisions.
module robo_ambiente #(
  parameter int ROWS        = 10,
  parameter int COLS        = 20,
  parameter int ROW_W       = 4,
  parameter int COL_W       = 5,
  parameter int CELL_W      = 4,
  parameter int LIFE_LEVE   = 3,
  parameter int LIFE_MEDIO  = 6,
  parameter int LIFE_PESADO = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [ROW_W-1:0] init_row,
  input  logic [COL_W-1:0] init_col,
  input  logic [1:0]       init_dir,
  input  logic             step_mode,
  input  logic             step,
  robo_ambiente_if.master  map,
  input  logic             avancar,
  input  logic             girar,
  input  logic             remover,
  output logic             head,
  output logic             left,
  output logic             under,
  output logic             barrier,
  output logic             sens_valid,
  output logic [ROW_W-1:0] linha,
  output logic [COL_W-1:0] coluna,
  output logic [1:0]       orientacao,
  output logic [3:0]       entulho_life,
  output logic             anomalia
);

  typedef enum logic [3:0] {
    IDLE, RD_F, RD_L, RD_U, CAP_U, SENSE, DECIDE, WAIT_STEP, HALT
  } state_t;

  localparam logic [1:0] DIR_N = 2'b00;
  localparam logic [1:0] DIR_S = 2'b01;
  localparam logic [1:0] DIR_L = 2'b10;
  localparam logic [1:0] DIR_O = 2'b11;

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [3:0] LIFE_L = 4'(LIFE_LEVE);
  localparam logic [3:0] LIFE_M = 4'(LIFE_MEDIO);
  localparam logic [3:0] LIFE_P = 4'(LIFE_PESADO);

  state_t state_reg, state_next;

  logic [ROW_W-1:0]  linha_reg, deb_row_reg, front_row, left_row;
  logic [COL_W-1:0]  coluna_reg, deb_col_reg, front_col, left_col;
  logic [1:0]        ori_reg;
  logic [3:0]        life_reg;
  logic [CELL_W-1:0] front_cell_reg, left_cell_reg, under_cell_reg;
  logic              head_reg, left_reg, under_reg, barrier_reg, sens_valid_reg;
  logic              robot_in, front_in, left_in;

  // Neighbour coordinates; *_in is false when the cell falls outside the map.
  always_comb begin
    robot_in  = (linha_reg <= ROW_MAX) && (coluna_reg <= COL_MAX);
    front_row = linha_reg;
    front_col = coluna_reg;
    left_row  = linha_reg;
    left_col  = coluna_reg;
    front_in  = 1'b0;
    left_in   = 1'b0;
    case (ori_reg)
      DIR_N: begin
        front_row = linha_reg - 1'b1;  front_in = (linha_reg != '0);
        left_col  = coluna_reg - 1'b1; left_in  = (coluna_reg != '0);
      end
      DIR_S: begin
        front_row = linha_reg + 1'b1;  front_in = (linha_reg < ROW_MAX);
        left_col  = coluna_reg + 1'b1; left_in  = (coluna_reg < COL_MAX);
      end
      DIR_L: begin
        front_col = coluna_reg + 1'b1; front_in = (coluna_reg < COL_MAX);
        left_row  = linha_reg - 1'b1;  left_in  = (linha_reg != '0);
      end
      default: begin
        front_col = coluna_reg - 1'b1; front_in = (coluna_reg != '0);
        left_row  = linha_reg + 1'b1;  left_in  = (linha_reg < ROW_MAX);
      end
    endcase
    front_in = front_in && robot_in;
    left_in  = left_in && robot_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (load) state_next = RD_F;
      RD_F:      state_next = RD_L;
      RD_L:      state_next = RD_U;
      RD_U:      state_next = CAP_U;
      CAP_U:     state_next = (!robot_in || map.rd_data == CELL_W'(1)) ? HALT : SENSE;
      SENSE:     state_next = DECIDE;
      DECIDE: begin
        if (life_reg == '0 && avancar && !front_in) state_next = HALT;
        else if (step_mode)                         state_next = WAIT_STEP;
        else                                        state_next = RD_F;
      end
      WAIT_STEP: if (step) state_next = RD_F;
      HALT:      state_next = HALT;
      default:   state_next = IDLE;
    endcase
  end

  // Map port: the clearing write lands in DECIDE so the very next front read sees it.
  always_comb begin
    map.rd_row  = '0;
    map.rd_col  = '0;
    map.wr_en   = 1'b0;
    map.wr_row  = deb_row_reg;
    map.wr_col  = deb_col_reg;
    map.wr_data = '0;
    case (state_reg)
      RD_F:   if (front_in) begin map.rd_row = front_row; map.rd_col = front_col; end
      RD_L:   if (left_in)  begin map.rd_row = left_row;  map.rd_col = left_col;  end
      RD_U:   if (robot_in) begin map.rd_row = linha_reg; map.rd_col = coluna_reg; end
      DECIDE: map.wr_en = (life_reg == 4'd1);
      default: ;
    endcase
    anomalia = (state_reg == HALT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      linha_reg      <= '0;
      coluna_reg     <= '0;
      ori_reg        <= '0;
      life_reg       <= '0;
      deb_row_reg    <= '0;
      deb_col_reg    <= '0;
      front_cell_reg <= '0;
      left_cell_reg  <= '0;
      under_cell_reg <= '0;
      head_reg       <= 1'b0;
      left_reg       <= 1'b0;
      under_reg      <= 1'b0;
      barrier_reg    <= 1'b0;
      sens_valid_reg <= 1'b0;
    end else begin
      sens_valid_reg <= (state_reg == SENSE);
      case (state_reg)
        IDLE: if (load) begin
          linha_reg  <= init_row;
          coluna_reg <= init_col;
          ori_reg    <= init_dir;
          life_reg   <= '0;
        end
        RD_L:  front_cell_reg <= front_in ? map.rd_data : '0;
        RD_U:  left_cell_reg  <= left_in ? map.rd_data : '0;
        CAP_U: under_cell_reg <= map.rd_data;
        SENSE: begin
          head_reg    <= !front_in || front_cell_reg == CELL_W'(1);
          left_reg    <= !left_in || left_cell_reg == CELL_W'(1);
          under_reg   <= (under_cell_reg == CELL_W'(2));
          barrier_reg <= front_in && front_cell_reg >= CELL_W'(3);
        end
        DECIDE: begin
          if (life_reg != '0) begin
            life_reg <= life_reg - 1'b1;
          end else if (avancar) begin
            if (front_in) begin
              linha_reg  <= front_row;
              coluna_reg <= front_col;
            end
          end else if (girar) begin
            case (ori_reg)
              DIR_N:   ori_reg <= DIR_O;
              DIR_O:   ori_reg <= DIR_S;
              DIR_S:   ori_reg <= DIR_L;
              default: ori_reg <= DIR_N;
            endcase
          end else if (remover && front_in) begin
            deb_row_reg <= front_row;
            deb_col_reg <= front_col;
            case (front_cell_reg)
              CELL_W'(3): life_reg <= LIFE_L;
              CELL_W'(4): life_reg <= LIFE_M;
              CELL_W'(5): life_reg <= LIFE_P;
              default:    life_reg <= '0;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign head         = head_reg;
  assign left         = left_reg;
  assign under        = under_reg;
  assign barrier      = barrier_reg;
  assign sens_valid   = sens_valid_reg;
  assign linha        = linha_reg;
  assign coluna       = coluna_reg;
  assign orientacao   = ori_reg;
  assign entulho_life = life_reg;

endmodule

// File: tb/tb_robo_ambiente.sv
// Self-checking bench for robo_ambiente: single-step vector table on a fixed map,
// plus hand-written multi-step sequences (walk, turning, debris, halt, step mode, reset).
module tb_robo_ambiente;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0, step_mode = 1'b0, step = 1'b0;
  logic [3:0] init_row = '0;
  logic [4:0] init_col = '0;
  logic [1:0] init_dir = '0;
  logic       avancar = 1'b0, girar = 1'b0, remover = 1'b0;
  logic       head, left, under, barrier, sens_valid, anomalia;
  logic [3:0] linha, entulho_life;
  logic [4:0] coluna;
  logic [1:0] orientacao;

  int vectors = 0;
  int miscompares = 0;

  robo_ambiente_if #(.ROW_W(4), .COL_W(5), .CELL_W(4)) map_bus ();

  robo_ambiente dut (
    .clock(clock), .reset(reset), .load(load),
    .init_row(init_row), .init_col(init_col), .init_dir(init_dir),
    .step_mode(step_mode), .step(step), .map(map_bus),
    .avancar(avancar), .girar(girar), .remover(remover),
    .head(head), .left(left), .under(under), .barrier(barrier),
    .sens_valid(sens_valid), .linha(linha), .coluna(coluna),
    .orientacao(orientacao), .entulho_life(entulho_life), .anomalia(anomalia)
  );

  always #5 clock = ~clock;

  // Map RAM model: map 0 is all zero, map 1 holds a few fixed cells.
  logic [3:0] mem [0:9][0:19];
  logic       map_init = 1'b0;
  logic       map_sel = 1'b0;

  function automatic logic [3:0] cell_init(input logic sel, input int r, input int c);
    if (!sel) return 4'd0;
    if (r == 2 && c == 4) return 4'd4;
    if (r == 3 && c == 3) return 4'd2;
    if (r == 4 && c == 4) return 4'd1;
    if (r == 5 && c == 6) return 4'd3;
    if (r == 7 && c == 7) return 4'd5;
    if (r == 8 && c == 8) return 4'd1;
    return 4'd0;
  endfunction

  always @(posedge clock) begin
    if (map_init) begin
      for (int i = 0; i < 10; i++)
        for (int j = 0; j < 20; j++)
          mem[i][j] <= cell_init(map_sel, i, j);
    end else if (map_bus.wr_en && int'(map_bus.wr_row) < 10 && int'(map_bus.wr_col) < 20) begin
      mem[int'(map_bus.wr_row)][int'(map_bus.wr_col)] <= map_bus.wr_data;
    end
    if (int'(map_bus.rd_row) < 10 && int'(map_bus.rd_col) < 20)
      map_bus.rd_data <= mem[int'(map_bus.rd_row)][int'(map_bus.rd_col)];
    else
      map_bus.rd_data <= 4'd0;
  end

  // Write monitor.
  int         wr_cnt = 0;
  logic [3:0] wr_r = '0, wr_d = '0;
  logic [4:0] wr_c = '0;
  always @(negedge clock) begin
    if (map_bus.wr_en) begin
      wr_cnt <= wr_cnt + 1;
      wr_r   <= map_bus.wr_row;
      wr_c   <= map_bus.wr_col;
      wr_d   <= map_bus.wr_data;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic do_reset(input logic sel);
    avancar = 1'b0; girar = 1'b0; remover = 1'b0; step = 1'b0; load = 1'b0;
    reset = 1'b1;
    map_sel = sel; map_init = 1'b1;
    @(negedge clock);
    map_init = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic start(input int r, input int c, input int d);
    init_row = 4'(r); init_col = 5'(c); init_dir = 2'(d);
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic wait_sv(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      got = sens_valid;
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL %s: sens_valid timeout got 0 expected 1", tag);
    end
  endtask

  task automatic count_sv(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (sens_valid) cnt++;
    end
  endtask

  typedef struct {
    int r, c, d, av, gi, re;
    int h, l, u, b;
    int er, ec, eo, el, ea;
  } vec_t;

  vec_t tbl [13];
  int   cnt, t0, t1, base;
  int   exp_ori [4];

  initial begin
    // r  c  d av gi re | h l u b | row col ori life anom
    tbl[0]  = '{5, 5, 0, 1, 0, 0,  0, 0, 0, 0,  4, 5, 0, 0, 0};
    tbl[1]  = '{0, 5, 0, 1, 0, 0,  1, 0, 0, 0,  0, 5, 0, 0, 1};
    tbl[2]  = '{2, 3, 2, 0, 0, 1,  0, 0, 0, 1,  2, 3, 2, 6, 0};
    tbl[3]  = '{3, 3, 1, 0, 1, 0,  0, 0, 1, 0,  3, 3, 2, 0, 0};
    tbl[4]  = '{4, 3, 2, 0, 1, 0,  1, 0, 0, 0,  4, 3, 0, 0, 0};
    tbl[5]  = '{5, 5, 2, 0, 0, 1,  0, 0, 0, 1,  5, 5, 2, 3, 0};
    tbl[6]  = '{7, 6, 2, 0, 0, 1,  0, 0, 0, 1,  7, 6, 2, 9, 0};
    tbl[7]  = '{0, 0, 3, 0, 1, 0,  1, 0, 0, 0,  0, 0, 1, 0, 0};
    tbl[8]  = '{9, 19, 1, 1, 0, 0, 1, 1, 0, 0,  9, 19, 1, 0, 1};
    tbl[9]  = '{4, 5, 3, 0, 0, 1,  1, 0, 0, 0,  4, 5, 3, 0, 0};
    tbl[10] = '{1, 4, 1, 0, 0, 0,  0, 0, 0, 1,  1, 4, 1, 0, 0};
    tbl[11] = '{3, 4, 0, 1, 0, 1,  0, 0, 0, 1,  2, 4, 0, 0, 0};
    tbl[12] = '{6, 6, 0, 0, 1, 1,  0, 0, 0, 1,  6, 6, 3, 0, 0};

    do_reset(1'b1);
    chk("reset_linha", int'(linha), 0);
    chk("reset_life", int'(entulho_life), 0);
    chk("reset_anom", int'(anomalia), 0);
    chk("reset_sv", int'(sens_valid), 0);

    foreach (tbl[k]) begin
      do_reset(1'b1);
      avancar = 1'(tbl[k].av); girar = 1'(tbl[k].gi); remover = 1'(tbl[k].re);
      start(tbl[k].r, tbl[k].c, tbl[k].d);
      wait_sv($sformatf("v%0d", k));
      chk($sformatf("v%0d_head", k), int'(head), tbl[k].h);
      chk($sformatf("v%0d_left", k), int'(left), tbl[k].l);
      chk($sformatf("v%0d_under", k), int'(under), tbl[k].u);
      chk($sformatf("v%0d_barrier", k), int'(barrier), tbl[k].b);
      @(negedge clock);
      avancar = 1'b0; girar = 1'b0; remover = 1'b0;
      chk($sformatf("v%0d_linha", k), int'(linha), tbl[k].er);
      chk($sformatf("v%0d_coluna", k), int'(coluna), tbl[k].ec);
      chk($sformatf("v%0d_ori", k), int'(orientacao), tbl[k].eo);
      chk($sformatf("v%0d_life", k), int'(entulho_life), tbl[k].el);
      chk($sformatf("v%0d_anom", k), int'(anomalia), tbl[k].ea);
    end

    // Walk north to the edge, then fall off.
    do_reset(1'b0);
    avancar = 1'b1;
    start(5, 5, 0);
    for (int k = 1; k <= 5; k++) begin
      wait_sv("walk");
      @(negedge clock);
      chk($sformatf("walk_linha%0d", k), int'(linha), 5 - k);
    end
    wait_sv("walk_edge");
    chk("walk_edge_head", int'(head), 1);
    @(negedge clock);
    avancar = 1'b0;
    chk("walk_anom", int'(anomalia), 1);
    chk("walk_linha_kept", int'(linha), 0);
    count_sv(20, cnt);
    chk("walk_halt_no_sv", cnt, 0);

    // Turn every step: L -> N -> O -> S -> L, 6-cycle period.
    do_reset(1'b0);
    exp_ori = '{0, 3, 1, 2};
    girar = 1'b1;
    start(2, 3, 2);
    t0 = 0;
    for (int k = 0; k < 4; k++) begin
      wait_sv("turn");
      t1 = int'($time);
      if (k > 0) chk($sformatf("turn_period%0d", k), (t1 - t0) / 10, 6);
      t0 = t1;
      @(negedge clock);
      chk($sformatf("turn_ori%0d", k), int'(orientacao), exp_ori[k]);
      chk($sformatf("turn_pos%0d", k), int'(linha) * 100 + int'(coluna), 203);
    end
    girar = 1'b0;

    // Debris code 4 ahead: remove, count down ignoring avancar, clear map.
    do_reset(1'b1);
    remover = 1'b1;
    start(2, 3, 2);
    wait_sv("deb");
    chk("deb_barrier", int'(barrier), 1);
    @(negedge clock);
    remover = 1'b0;
    chk("deb_life_load", int'(entulho_life), 6);
    avancar = 1'b1;
    base = wr_cnt;
    for (int k = 5; k >= 0; k--) begin
      wait_sv("deb_cd");
      if (k > 0) chk($sformatf("deb_no_wr%0d", k), wr_cnt - base, 0);
      @(negedge clock);
      chk($sformatf("deb_life%0d", k), int'(entulho_life), k);
      chk($sformatf("deb_col%0d", k), int'(coluna), 3);
    end
    avancar = 1'b0;
    chk("deb_wr_count", wr_cnt - base, 1);
    chk("deb_wr_row", int'(wr_r), 2);
    chk("deb_wr_col", int'(wr_c), 4);
    chk("deb_wr_data", int'(wr_d), 0);
    chk("deb_map_cleared", int'(mem[2][4]), 0);
    wait_sv("deb_after");
    chk("deb_barrier_gone", int'(barrier), 0);

    // Start on a wall cell: halt, load ignored, reset clears.
    do_reset(1'b1);
    start(8, 8, 0);
    count_sv(20, cnt);
    chk("wall_no_sv", cnt, 0);
    chk("wall_anom", int'(anomalia), 1);
    start(1, 1, 0);
    @(negedge clock);
    chk("wall_load_ignored", int'(linha), 8);
    reset = 1'b1;
    #1;
    chk("wall_reset_anom", int'(anomalia), 0);
    chk("wall_reset_linha", int'(linha), 0);
    @(negedge clock);
    reset = 1'b0;

    // Step mode: one sensing per step pulse, pulse during RD_L ignored.
    do_reset(1'b0);
    step_mode = 1'b1;
    start(5, 5, 0);
    wait_sv("step_first");
    count_sv(20, cnt);
    chk("step_waits", cnt, 0);
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
    @(negedge clock);
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
    count_sv(20, cnt);
    chk("step_one_sv", cnt, 1);
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
    count_sv(12, cnt);
    chk("step_again_sv", cnt, 1);
    step_mode = 1'b0;

    // Reset in the middle of a countdown.
    do_reset(1'b1);
    remover = 1'b1;
    start(2, 3, 2);
    wait_sv("rst_cd");
    @(negedge clock);
    remover = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_sv("rst_cd_step");
      @(negedge clock);
    end
    chk("rst_life_before", int'(entulho_life), 3);
    #2 reset = 1'b1;
    #1;
    chk("rst_life", int'(entulho_life), 0);
    chk("rst_pos", int'(linha) * 100 + int'(coluna), 0);
    chk("rst_barrier", int'(barrier), 0);
    chk("rst_wr_en", int'(map_bus.wr_en), 0);
    base = wr_cnt;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    count_sv(60, cnt);
    chk("rst_idle_no_sv", cnt, 0);
    chk("rst_no_wr", wr_cnt - base, 0);
    chk("rst_map_kept", int'(mem[2][4]), 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
